// File: rtl/clkdiv_prog_drv.sv
// Programmable integer clock divider driving the 14x output buffer input.
// Latency: O is registered, 1 CLK after the counter phase; ratio change lands at the next period boundary.
// Backpressure: LOAD/ACK handshake; LOAD is ignored while BUSY, ACK pulses one cycle when the ratio is applied.
//
// Ports:
//   CLK   - clock, rising edge
//   RSTB  - asynchronous active-low reset
//   EN    - divider enable; dropping it forces O low on the next edge
//   DIV   - requested ratio, captured only with LOAD while idle (values <2 clamp to 2)
//   LOAD  - ratio-change request, level sampled each edge
//   BUSY  - a captured ratio is waiting for a period boundary
//   ACK   - one-cycle pulse after the edge that applied the pending ratio
//   O     - divided clock, straight from a flop so the buffer never sees a glitch

module clkdiv_prog_drv #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             BUSY,
  output logic             ACK,
  output logic             O
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] nact_q,  nact_d;
  logic [WIDTH-1:0] npend_q, npend_d;
  logic             o_q,     o_d;
  logic             ack_q,   ack_d;
  logic             busy_q,  busy_d;

  // One extra bit so ceil(N/2) does not overflow when N is the max ratio.
  logic [WIDTH:0]   high_time;
  logic             last_cnt;
  logic             boundary;
  logic [WIDTH-1:0] div_clamped;

  always_comb begin
    high_time   = ({1'b0, nact_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    last_cnt    = (cnt_q == (nact_q - ONE));
    // Every disabled edge counts as a boundary, so a pending ratio never waits on EN.
    boundary    = !EN || last_cnt;
    div_clamped = (DIV < DIV_MIN) ? DIV_MIN : DIV;

    // Phase and output both use the ratio in force before this edge; a new
    // ratio only takes over once the counter is back at zero.
    cnt_d = (EN && !last_cnt) ? (cnt_q + ONE) : '0;
    o_d   = EN && ({1'b0, cnt_q} < high_time);

    state_d = state_q;
    nact_d  = nact_q;
    npend_d = npend_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A capture on a boundary edge is deliberately not applied on the same edge.
        if (LOAD) begin
          npend_d = div_clamped;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          nact_d  = npend_q;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_PEND);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nact_q  <= DIV_RST;
      npend_q <= DIV_RST;
      o_q     <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nact_q  <= nact_d;
      npend_q <= npend_d;
      o_q     <= o_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign O    = o_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_clkdiv_prog_drv.sv
// Self-checking bench for clkdiv_prog_drv.
// Reference model tracks the start edge of the current period and derives phase with modulo arithmetic.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.

module tb_clkdiv_prog_drv;

  logic       CLK = 1'b0;
  logic       RSTB;
  logic       EN;
  logic [3:0] DIV;
  logic       LOAD;
  logic       BUSY;
  logic       ACK;
  logic       O;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_k;      // number of edges processed since time zero
  int m_seg;    // edge index at which the current period started
  int m_nact;
  int m_npend;
  bit m_pend;
  bit m_o;
  bit m_ack;

  clkdiv_prog_drv #(.WIDTH(4), .DEFAULT_DIV(2)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .EN   (EN),
    .DIV  (DIV),
    .LOAD (LOAD),
    .BUSY (BUSY),
    .ACK  (ACK),
    .O    (O)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_seg   = m_k;
    m_nact  = 2;
    m_npend = 2;
    m_pend  = 0;
    m_o     = 0;
    m_ack   = 0;
  endtask

  task automatic model_step();
    int p;
    bit b;
    if (EN) begin
      p   = (m_k - m_seg) % m_nact;
      m_o = (p < (m_nact + 1) / 2);
      b   = (p == m_nact - 1);
    end else begin
      m_o = 0;
      b   = 1;
    end
    if (b) m_seg = m_k + 1;
    m_ack = 0;
    if (m_pend) begin
      if (b) begin
        m_nact = m_npend;
        m_ack  = 1;
        m_pend = 0;
      end
    end else if (LOAD) begin
      m_npend = (DIV < 2) ? 2 : int'(DIV);
      m_pend  = 1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    m_k++;
    #1;
  endtask

  task automatic wait_ack(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (ACK === 1'b1) got = 1;
    end
  endtask

  task automatic test_reset();
    RSTB = 1'b0; EN = 1'b0; LOAD = 1'b0; DIV = 4'd0;
    m_k = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({O, ACK, BUSY} !== 3'b000)
      begin errors++; $display("FAIL reset_outputs: got O/ACK/BUSY=%b expected 000", {O, ACK, BUSY}); end
    RSTB = 1'b1;
  endtask

  task automatic test_default_ratio();
    EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({O, ACK, BUSY} !== {(i % 2 == 0), 2'b00})
        begin errors++; $display("FAIL default_ratio[%0d]: got O/ACK/BUSY=%b expected %b", i, {O, ACK, BUSY}, {(i % 2 == 0), 2'b00}); end
    end
  endtask

  task automatic test_ratio_change();
    bit got;
    LOAD = 1'b1; DIV = 4'd5;
    tick();
    LOAD = 1'b0;
    checks++;
    if (BUSY !== 1'b1)
      begin errors++; $display("FAIL load5_busy: got BUSY=%b expected 1", BUSY); end
    wait_ack(20, got);
    checks++;
    if (!got || O !== 1'b0)
      begin errors++; $display("FAIL load5_ack: got ack_seen=%0d O=%b expected ack_seen=1 O=0", got, O); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({O, ACK, BUSY} !== {(i % 5 < 3), 2'b00})
        begin errors++; $display("FAIL period5[%0d]: got O/ACK/BUSY=%b expected %b", i, {O, ACK, BUSY}, {(i % 5 < 3), 2'b00}); end
    end
  endtask

  task automatic test_clamp();
    bit got;
    for (int d = 0; d < 2; d++) begin
      LOAD = 1'b1; DIV = 4'(d);
      tick();
      LOAD = 1'b0;
      wait_ack(20, got);
      checks++;
      if (!got)
        begin errors++; $display("FAIL clamp_ack_div%0d: got no ACK expected one", d); end
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++;
        if (O !== (i % 2 == 0))
          begin errors++; $display("FAIL clamp_div%0d[%0d]: got O=%b expected %b", d, i, O, (i % 2 == 0)); end
      end
    end
  endtask

  task automatic test_busy_ignores_load();
    int acks;
    int n;
    acks = 0;
    n = 0;
    LOAD = 1'b1; DIV = 4'd7;
    tick();
    DIV = 4'd3;
    while (BUSY === 1'b1 && n < 20) begin
      tick();
      n++;
      if (ACK === 1'b1) acks++;
    end
    LOAD = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ACK === 1'b1) acks++;
      checks++;
      if ({O, BUSY} !== {(i % 7 < 4), 1'b0})
        begin errors++; $display("FAIL period7[%0d]: got O/BUSY=%b expected %b", i, {O, BUSY}, {(i % 7 < 4), 1'b0}); end
    end
    checks++;
    if (acks !== 1)
      begin errors++; $display("FAIL single_ack: got %0d ACK pulses expected 1", acks); end
  endtask

  task automatic test_en_drop();
    bit got;
    LOAD = 1'b1; DIV = 4'd6;
    tick();
    LOAD = 1'b0;
    wait_ack(20, got);
    checks++;
    if (!got)
      begin errors++; $display("FAIL load6_ack: got no ACK expected one"); end
    LOAD = 1'b1; DIV = 4'd4;
    tick();
    LOAD = 1'b0;
    checks++;
    if ({O, BUSY} !== 2'b11)
      begin errors++; $display("FAIL en_drop_setup: got O/BUSY=%b expected 11", {O, BUSY}); end
    EN = 1'b0;
    tick();
    checks++;
    if ({O, ACK, BUSY} !== 3'b010)
      begin errors++; $display("FAIL en_drop_apply: got O/ACK/BUSY=%b expected 010", {O, ACK, BUSY}); end
    EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({O, ACK} !== {(i % 4 < 2), 1'b0})
        begin errors++; $display("FAIL period4[%0d]: got O/ACK=%b expected %b", i, {O, ACK}, {(i % 4 < 2), 1'b0}); end
    end
  endtask

  task automatic test_async_reset();
    bit got;
    LOAD = 1'b1; DIV = 4'd9;
    tick();
    LOAD = 1'b0;
    wait_ack(20, got);
    checks++;
    if (!got)
      begin errors++; $display("FAIL load9_ack: got no ACK expected one"); end
    tick();
    LOAD = 1'b1; DIV = 4'd3;
    tick();
    LOAD = 1'b0;
    checks++;
    if ({O, BUSY} !== 2'b11)
      begin errors++; $display("FAIL pre_reset: got O/BUSY=%b expected 11", {O, BUSY}); end
    #2;
    RSTB = 1'b0;
    #1;
    checks++;
    if ({O, ACK, BUSY} !== 3'b000)
      begin errors++; $display("FAIL async_reset: got O/ACK/BUSY=%b expected 000", {O, ACK, BUSY}); end
    model_reset();
    RSTB = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({O, ACK, BUSY} !== {(i % 2 == 0), 2'b00})
        begin errors++; $display("FAIL post_reset[%0d]: got O/ACK/BUSY=%b expected %b", i, {O, ACK, BUSY}, {(i % 2 == 0), 2'b00}); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      EN   = ($urandom_range(0, 11) != 0);
      LOAD = ($urandom_range(0, 5) == 0);
      DIV  = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if ({O, ACK, BUSY} !== {m_o, m_ack, m_pend})
        begin errors++; $display("FAIL random[%0d]: got O/ACK/BUSY=%b expected %b", i, {O, ACK, BUSY}, {m_o, m_ack, m_pend}); end
    end
  endtask

  initial begin
    test_reset();
    test_default_ratio();
    test_ratio_change();
    test_clamp();
    test_busy_ignores_load();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
